// File: rtl/slave_port_if.sv
// Serial system-bus signal bundle shared by a master port and a slave port.
// The master drives address/write bits and read flow control; the slave answers.
interface slave_port_if;
    logic mode;
    logic wr_bus;
    logic rd_bus;
    logic ack;
    logic master_valid;
    logic slave_ready;
    logic master_ready;
    logic slave_valid;

    modport master (
        output mode, wr_bus, master_valid, master_ready,
        input  rd_bus, ack, slave_ready, slave_valid
    );

    modport slave (
        input  mode, wr_bus, master_valid, master_ready,
        output rd_bus, ack, slave_ready, slave_valid
    );
endinterface

// File: rtl/slave_port.sv
// Serial system-bus slave port: 16-bit address in, then 8 write bits in or 8 read bits out.
// Optional macro SLAVE_PORT_BUSY_EN adds an s_busy input that stalls write data and read requests.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for the first address bit
// ADDR      | shifting in address bits 2..16, device-select check on bit 6
// WR_DATA   | shifting in 8 write-data bits
// WR_COMMIT | one-cycle s_wr_en strobe to the peripheral
// RD_REQ    | one-cycle s_rd_en strobe (held while busy)
// RD_WAIT   | waiting for s_rd_valid from the peripheral
// RD_DATA   | serialising the read byte MSB-first
// IGNORE    | deaf until the bus is idle for a cycle
module slave_port #(
    parameter logic [3:0] SLAVE_ID   = 4'h1,
    parameter int         ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    slave_port_if.slave           bus,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [7:0]            s_wr_data,
    output logic                  s_wr_en,
    output logic                  s_rd_en,
    input  logic [7:0]            s_rd_data,
    input  logic                  s_rd_valid
`ifdef SLAVE_PORT_BUSY_EN
    ,
    input  logic                  s_busy
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_DATA,
        WR_COMMIT,
        RD_REQ,
        RD_WAIT,
        RD_DATA,
        IGNORE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] addr_sh;
    logic [7:0]  data_sh;
    logic        mode_q;
    logic        busy;
    logic [15:0] addr_next;
    logic        id_match;
    logic        rx_beat;
    logic        tx_beat;

`ifdef SLAVE_PORT_BUSY_EN
    assign busy = s_busy;
`else
    assign busy = 1'b0;
`endif

    assign addr_next = {addr_sh[14:0], bus.wr_bus};
    // After five bits the device-select nibble sits in addr_sh[4:1]; bit 0 is address bit 11.
    assign id_match  = (addr_sh[4:1] == SLAVE_ID);

    // Outputs are forced low while reset is held so an abort never leaks a strobe.
    assign bus.slave_ready = !rstn && ((state == IDLE) || (state == ADDR) ||
                                       ((state == WR_DATA) && !busy));
    assign bus.ack         = !rstn && (state == ADDR) && (cnt == 5'd5) &&
                             bus.master_valid && id_match;
    assign bus.slave_valid = !rstn && (state == RD_DATA) && bus.master_ready;
    assign bus.rd_bus      = !rstn && (state == RD_DATA) && data_sh[7];
    assign s_wr_en         = !rstn && (state == WR_COMMIT);
    assign s_wr_data       = (!rstn && (state == WR_COMMIT)) ? data_sh : 8'h00;
    assign s_rd_en         = !rstn && (state == RD_REQ) && !busy;

    assign rx_beat = bus.master_valid && bus.slave_ready;
    assign tx_beat = bus.slave_valid && bus.master_ready;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            addr_sh <= 16'h0000;
            data_sh <= 8'h00;
            mode_q  <= 1'b0;
            s_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_beat) begin
                        addr_sh <= {15'd0, bus.wr_bus};
                        cnt     <= 5'd1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (!bus.master_valid) begin
                        cnt   <= 5'd0;
                        state <= IDLE;
                    end else begin
                        addr_sh <= addr_next;
                        cnt     <= cnt + 5'd1;
                        if (cnt == 5'd5) begin
                            if (id_match) begin
                                mode_q <= bus.mode;
                            end else begin
                                cnt   <= 5'd0;
                                state <= IGNORE;
                            end
                        end else if (cnt == 5'd15) begin
                            s_addr <= addr_next[ADDR_WIDTH-1:0];
                            cnt    <= 5'd0;
                            state  <= mode_q ? WR_DATA : RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_beat) begin
                        data_sh <= {data_sh[6:0], bus.wr_bus};
                        if (cnt == 5'd7) begin
                            cnt   <= 5'd0;
                            state <= WR_COMMIT;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                WR_COMMIT: begin
                    state <= IGNORE;
                end
                RD_REQ: begin
                    if (!busy) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (s_rd_valid) begin
                        data_sh <= s_rd_data;
                        cnt     <= 5'd0;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (tx_beat) begin
                        data_sh <= {data_sh[6:0], 1'b0};
                        if (cnt == 5'd7) begin
                            cnt   <= 5'd0;
                            state <= IGNORE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                IGNORE: begin
                    if (!bus.master_valid && !bus.master_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Bus-side responder for the serial system-bus protocol: the peer of the master port at the other end of the bus.
- Deserialises a 16-bit address MSB-first, acknowledges when the device-select bits match its ID, then either:
  - receives 8 write bits and commits them to the local peripheral, or
  - fetches a byte from the peripheral and serialises it back MSB-first.
- Sits between the bus interconnect and one memory/peripheral slave.

Parameters:
- SLAVE_ID, 4'h1, device select compared against address bits [15:12].
- ADDR_WIDTH, 12, local address width (1..12); s_addr = addr[ADDR_WIDTH-1:0].

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-high (1 = reset)
- mode  in  1  transaction type from master; 1 = write, 0 = read; stable for the whole transaction
- wr_bus  in  1  serial address/write-data bit, MSB first
- rd_bus  out  1  serial read-data bit, MSB first
- ack  out  1  address match indication, combinational
- master_valid  in  1  master has an address/write bit on wr_bus
- slave_ready  out  1  slave accepts the wr_bus bit
- master_ready  in  1  master accepts read bits
- slave_valid  out  1  rd_bus bit valid
- s_addr  out  ADDR_WIDTH  local address
- s_wr_data  out  8  write data
- s_wr_en  out  1  one-cycle write strobe
- s_rd_en  out  1  one-cycle read request
- s_rd_data  in  8  peripheral read data
- s_rd_valid  in  1  s_rd_data valid

Behaviour:
- Beats:
  - Receive beat = master_valid & slave_ready.
  - Transmit beat = slave_valid & master_ready.
- Bit counter: 5 bits. Shift register: 16-bit address, 8-bit data.
- Reset: state IDLE; all outputs 0; counters and registers 0. Reset mid-transaction aborts immediately with no strobes.
- IDLE:
  - slave_ready=1.
  - Receive beat: shift in bit 0, cnt=1 -> ADDR.
- ADDR:
  - slave_ready=1; each receive beat shifts wr_bus in and increments cnt.
  - ack = (cnt==5) & master_valid & (addr_sh[4:1]==SLAVE_ID). It is valid in the same cycle as the 6th beat and is 0 at all other times.
  - On the 6th beat:
    - ID match: latch mode, continue.
    - No match: -> IGNORE.
  - master_valid low while in ADDR (abort or timeout restart): -> IDLE, cnt=0.
  - On the 16th beat: s_addr latched, cnt=0, then mode=1 -> WR_DATA, mode=0 -> RD_REQ.
- WR_DATA:
  - slave_ready=1; 8 receive beats shift into the data register.
  - After the 8th beat -> WR_COMMIT.
- WR_COMMIT:
  - s_wr_en=1 for exactly one cycle, with s_addr/s_wr_data stable.
  - -> IGNORE.
- RD_REQ: s_rd_en=1 for one cycle -> RD_WAIT.
- RD_WAIT:
  - s_rd_valid is sampled from the cycle after s_rd_en and may arrive at any later cycle.
  - On s_rd_valid: capture s_rd_data, cnt=0 -> RD_DATA.
- RD_DATA:
  - slave_valid = master_ready; rd_bus = data_sh[7].
  - Each transmit beat shifts left and increments cnt.
  - After the 8th beat -> IGNORE.
- IGNORE:
  - slave_ready=0, slave_valid=0.
  - Waits for master_valid==0 & master_ready==0 for one cycle, then -> IDLE. This keeps non-selected or finished slaves from capturing the rest of another transaction.
- Outputs outside their owning state are 0. s_addr holds its last latched value.
- Strobe latency:
  - Write: s_wr_en asserts 1 cycle after the last write beat.
  - Read: s_rd_en asserts 1 cycle after the 16th address beat.

Optional Feature:
- SLAVE_PORT_BUSY_EN: adds input s_busy (1 bit).
  - In WR_DATA, slave_ready = ~s_busy.
  - RD_REQ holds without asserting s_rd_en while s_busy=1.
  - IDLE and ADDR are unaffected.
- Without the macro: no port; behaviour as if s_busy=0.

Test Plan:
- Write, addr 0x1A5C, data 0xA7, SLAVE_ID=1 -> ack pulses on the 6th address beat; s_wr_en pulses once with s_addr=0xA5C, s_wr_data=0xA7; then IDLE.
- Read, addr 0x1033, peripheral returns s_rd_data=0x3C 2 cycles after s_rd_en -> s_addr=0x033; rd_bus beats 0,0,1,1,1,1,0,0; slave_valid only while master_ready=1.
- Addr 0x2000 (ID mismatch), write 0xFF -> ack never 1; no s_wr_en/s_rd_en; slave in IGNORE until the bus idles, then accepts the next transaction to 0x1001.
- master_valid dropped after 3 address beats (timeout restart), then full write 0x1004/0x55 -> first partial address discarded; single commit to 0x004 with 0x55.
- rstn asserted during WR_DATA after 4 bits -> all outputs 0 next cycle; no s_wr_en; a subsequent write 0x1010/0x0F commits correctly.
- (SLAVE_PORT_BUSY_EN) s_busy=1 for 5 cycles mid WR_DATA -> slave_ready low for those cycles; data 0xC3 still committed intact.
